// File: rtl/filt_pkg.sv
// filt_pkg: shared types and helpers for the filt_dec bitstream filter.
//   filt_state_t : controller states (IDLE, ACCUM, OUT)
//   acc_width    : accumulator width that cannot overflow for TAPS signed terms
//   idx_width    : width of a row index for n rows (at least 1 bit)
//   saturate     : clamp a signed value into an out_w-bit signed range
package filt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } filt_state_t;

    function automatic int acc_width(input int coef_w, input int taps);
        return coef_w + $clog2(taps) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/filt_dec_if.sv
// filt_dec_if: bitstream, coefficient-write and result signals of filt_dec.
//   master : source side (drives BitIn, FILTER, CoefWe/CoefAddr/CoefData)
//   slave  : filter side (drives Dout, Push, Busy, Overrun)
interface filt_dec_if #(
    parameter int TAPS   = 512,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16
) ();
    logic                       BitIn;
    logic                       FILTER;
    logic                       CoefWe;
    logic [$clog2(TAPS)-1:0]    CoefAddr;
    logic signed [COEF_W-1:0]   CoefData;
    logic signed [OUT_W-1:0]    Dout;
    logic                       Push;
    logic                       Busy;
    logic                       Overrun;

    modport master (
        output BitIn, FILTER, CoefWe, CoefAddr, CoefData,
        input  Dout, Push, Busy, Overrun
    );

    modport slave (
        input  BitIn, FILTER, CoefWe, CoefAddr, CoefData,
        output Dout, Push, Busy, Overrun
    );
endinterface

// File: rtl/filt_coef_ram.sv
// filt_coef_ram: coefficient store, TAPS/LANES rows of LANES packed coefficients.
//   Clock : system clock
//   we    : write strobe, one coefficient (tap-granular lane enable)
//   waddr : tap index k; row = k / LANES, lane = k % LANES
//   wdata : signed coefficient
//   raddr : row index for the synchronous read
//   rdata : registered row, lane l at bits [l*COEF_W +: COEF_W]
// A write to the row being read is forwarded into rdata, so a write issued
// in the same cycle as the row-0 prefetch is seen by the computation.
module filt_coef_ram
    import filt_pkg::*;
#(
    parameter int TAPS   = 512,
    parameter int LANES  = 4,
    parameter int COEF_W = 16
) (
    input  logic                                Clock,
    input  logic                                we,
    input  logic [$clog2(TAPS)-1:0]             waddr,
    input  logic signed [COEF_W-1:0]            wdata,
    input  logic [idx_width(TAPS/LANES)-1:0]    raddr,
    output logic [LANES*COEF_W-1:0]             rdata
);
    localparam int N  = TAPS / LANES;
    localparam int IW = idx_width(N);
    localparam int AW = $clog2(TAPS);
    localparam int LW = $clog2(LANES);

    logic [LANES*COEF_W-1:0] mem [N];
    logic [AW-1:0]           wrow_full;
    logic [IW-1:0]           wrow;
    logic [LANES-1:0]        lane_we;

    always_comb begin
        wrow_full = waddr >> LW;
        wrow      = IW'(wrow_full);
        lane_we   = '0;
        for (int l = 0; l < LANES; l++)
            lane_we[l] = we && ((waddr & AW'(LANES - 1)) == AW'(l));
    end

    always_ff @(posedge Clock) begin
        for (int l = 0; l < LANES; l++) begin
            if (lane_we[l])
                mem[wrow][l*COEF_W +: COEF_W] <= wdata;
            if (lane_we[l] && (wrow == raddr))
                rdata[l*COEF_W +: COEF_W] <= wdata;
            else
                rdata[l*COEF_W +: COEF_W] <= mem[raddr][l*COEF_W +: COEF_W];
        end
    end

endmodule

// File: rtl/filt_dec.sv
// filt_dec: 1-bit bitstream FIR with programmable signed coefficients.
//   Clock : system clock
//   Reset : synchronous, active-high
//   bus   : filt_dec_if slave -- BitIn/FILTER/coef write in, Dout/Push/Busy/Overrun out
// Each tap adds +coef for a 1 history bit and -coef for a 0 bit, LANES taps
// per cycle; the result is shifted right by SHIFT and saturated to OUT_W.
//
// state | meaning
// IDLE  | waiting for FILTER; prefetching coefficient row 0
// ACCUM | adding LANES terms per cycle for TAPS/LANES cycles
// OUT   | registering saturated result; Push follows
module filt_dec
    import filt_pkg::*;
#(
    parameter int TAPS   = 512,
    parameter int LANES  = 4,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    filt_dec_if.slave   bus
);
    localparam int N     = TAPS / LANES;
    localparam int IW    = idx_width(N);
    localparam int ACC_W = acc_width(COEF_W, TAPS);

    filt_state_t              state, state_nxt;
    logic [TAPS-1:0]          hist;
    logic [TAPS-1:0]          snap;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  lane_sum;
    logic [IW-1:0]            idx;
    logic [IW-1:0]            rd_idx;
    logic [LANES*COEF_W-1:0]  coef_row;
    logic signed [OUT_W-1:0]  dout_q;
    logic                     push_q;
    logic                     busy;
    logic                     start;
    logic                     last;

    assign busy        = (state != IDLE);
    assign last        = (idx == IW'(N - 1));
    assign bus.Busy    = busy;
    assign bus.Overrun = bus.FILTER && busy;
    assign bus.Dout    = dout_q;
    assign bus.Push    = push_q;

    filt_coef_ram #(
        .TAPS   (TAPS),
        .LANES  (LANES),
        .COEF_W (COEF_W)
    ) u_coef_ram (
        .Clock (Clock),
        .we    (bus.CoefWe && !busy),
        .waddr (bus.CoefAddr),
        .wdata (bus.CoefData),
        .raddr (rd_idx),
        .rdata (coef_row)
    );

    always_ff @(posedge Clock) begin
        if (Reset)
            hist <= '0;
        else
            hist <= {bus.BitIn, hist[TAPS-1:1]};
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.FILTER) begin
                    start     = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (last)
                    state_nxt = OUT;
            end
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read one row ahead of idx; outside ACCUM (and on the last row) point at
    // row 0 so the first row is already registered when ACCUM begins.
    always_comb begin
        if (state == ACCUM && !last)
            rd_idx = idx + IW'(1);
        else
            rd_idx = '0;
    end

    // snap is shifted down by LANES per ACCUM cycle, so its low LANES bits
    // always belong to the row currently in coef_row.
    always_comb begin : p_lane_sum
        logic signed [COEF_W-1:0] c;
        logic signed [ACC_W-1:0]  ce;
        lane_sum = '0;
        c        = '0;
        ce       = '0;
        for (int l = 0; l < LANES; l++) begin
            c        = coef_row[l*COEF_W +: COEF_W];
            ce       = c;
            lane_sum = lane_sum + (snap[l] ? ce : -ce);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            snap   <= '0;
            acc    <= '0;
            idx    <= '0;
            dout_q <= '0;
            push_q <= 1'b0;
        end else begin
            push_q <= (state == OUT);
            if (start) begin
                snap <= hist;
                acc  <= '0;
                idx  <= '0;
            end else if (state == ACCUM) begin
                acc  <= acc + lane_sum;
                snap <= snap >> LANES;
                idx  <= idx + IW'(1);
            end
            if (state == OUT)
                dout_q <= OUT_W'(saturate(64'(acc >>> SHIFT), OUT_W));
        end
    end

endmodule

// File: tb/tb_filt_dec.sv
// tb_filt_dec: directed bench for filt_dec with TAPS=8, LANES=2 (4 ACCUM cycles,
// result valid 5 cycles after the FILTER edge). Inputs change on the falling
// edge; outputs are read on the falling edge.
module tb_filt_dec;
    localparam int TAPS   = 8;
    localparam int LANES  = 2;
    localparam int COEF_W = 16;
    localparam int OUT_W  = 16;

    logic Clock;
    logic Reset;
    int   tests  = 0;
    int   failed = 0;

    filt_dec_if #(.TAPS(TAPS), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();

    filt_dec #(
        .TAPS   (TAPS),
        .LANES  (LANES),
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W),
        .SHIFT  (0)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // bits[0] is shifted in first and ends up in hist[0].
    task automatic load_bits(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) begin
            bus.BitIn = bits[i];
            @(negedge Clock);
        end
    endtask

    task automatic wr_coef(input int k, input int v);
        bus.CoefWe   = 1'b1;
        bus.CoefAddr = 3'(k);
        bus.CoefData = 16'(v);
        @(negedge Clock);
        bus.CoefWe   = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < TAPS; k++)
            wr_coef(k, v);
    endtask

    task automatic do_filter(input string tag, input int expv, input bit we,
                             input int wk, input int wv);
        int cyc;
        bus.FILTER   = 1'b1;
        bus.CoefWe   = we;
        bus.CoefAddr = 3'(wk);
        bus.CoefData = 16'(wv);
        @(negedge Clock);
        bus.FILTER = 1'b0;
        bus.CoefWe = 1'b0;
        chk({tag, "_busy"}, bus.Busy, 1);
        cyc = 0;
        while (bus.Push !== 1'b1 && cyc < 30) begin
            @(negedge Clock);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 5);
        chk({tag, "_dout"}, bus.Dout, expv);
        @(negedge Clock);
        chk({tag, "_push_single"}, bus.Push, 0);
        chk({tag, "_dout_hold"}, bus.Dout, expv);
    endtask

    initial begin
        int pushes;
        logic signed [31:0] got;

        Reset        = 1'b1;
        bus.BitIn    = 1'b0;
        bus.FILTER   = 1'b0;
        bus.CoefWe   = 1'b0;
        bus.CoefAddr = '0;
        bus.CoefData = '0;
        repeat (3) @(negedge Clock);
        chk("rst_dout", bus.Dout, 0);
        chk("rst_push", bus.Push, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_overrun", bus.Overrun, 0);
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            chk("idle_dout", bus.Dout, 0);
            chk("idle_push", bus.Push, 0);
            chk("idle_busy", bus.Busy, 0);
        end

        set_all(1);
        load_bits(8'hFF);
        do_filter("ones_c1", 8, 1'b0, 0, 0);
        load_bits(8'h55);
        do_filter("alt_c1", 0, 1'b0, 0, 0);
        load_bits(8'h00);
        do_filter("zeros_c1", -8, 1'b0, 0, 0);

        set_all(32767);
        load_bits(8'hFF);
        do_filter("sat_pos", 32767, 1'b0, 0, 0);
        load_bits(8'h00);
        do_filter("sat_neg", -32768, 1'b0, 0, 0);

        // coef[k] = k+1; 0xCA sets taps 1,3,6,7: +(2+4+7+8) -(1+3+5+6) = 6
        for (int k = 0; k < TAPS; k++)
            wr_coef(k, k + 1);
        load_bits(8'hCA);
        do_filter("ramp", 6, 1'b0, 0, 0);

        // second FILTER two cycles after acceptance plus a write while busy
        load_bits(8'hCA);
        bus.FILTER = 1'b1;
        @(negedge Clock);
        bus.FILTER = 1'b0;
        bus.BitIn  = 1'b1;
        @(negedge Clock);
        bus.FILTER   = 1'b1;
        bus.CoefWe   = 1'b1;
        bus.CoefAddr = 3'd7;
        bus.CoefData = 16'd1000;
        #1;
        chk("ovr_pulse", bus.Overrun, 1);
        @(negedge Clock);
        bus.FILTER = 1'b0;
        bus.CoefWe = 1'b0;
        #1;
        chk("ovr_clear", bus.Overrun, 0);
        pushes = 0;
        got    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (bus.Push === 1'b1) begin
                pushes++;
                got = bus.Dout;
            end
        end
        chk("ovr_push_count", pushes, 1);
        chk("ovr_dout", got, 6);

        load_bits(8'hCA);
        do_filter("coef_kept", 6, 1'b0, 0, 0);

        // coef[0] written to 100 in the FILTER cycle: 6 + 1 - 100 = -93
        load_bits(8'hCA);
        do_filter("wr_same_cycle", -93, 1'b1, 0, 100);

        // reset during ACCUM cycle 2
        load_bits(8'hFF);
        bus.FILTER = 1'b1;
        @(negedge Clock);
        bus.FILTER = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        chk("rstmid_busy", bus.Busy, 0);
        chk("rstmid_dout", bus.Dout, 0);
        chk("rstmid_push", bus.Push, 0);
        Reset  = 1'b0;
        pushes = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (bus.Push === 1'b1)
                pushes++;
        end
        chk("rstmid_no_push", pushes, 0);

        // coefficients survive reset: 100+2+3+4+5+6+7+8 = 135
        load_bits(8'hFF);
        do_filter("post_reset", 135, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
